// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter/sequencer for a 128x8 single-port RAM.
// Optional RAM_ARB_ADDR_CHECK_EN: out-of-range address gets gnt+err, no RAM access.
module ram_arbiter #(
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int DEPTH = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          err0,
   output logic          err1,
   output logic          ram_cs,
   output logic          ram_wr_e,
   output logic          ram_o_e,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_RDATA = 2'd3;

   logic [1:0]    r_state;
   logic          r_last;
   logic          r_port;
   logic [AW-1:0] r_addr;
   logic          r_gnt0, r_gnt1;
   logic          r_rv0, r_rv1;
   logic [DW-1:0] r_rd0, r_rd1;
   logic          r_err0, r_err1;
   logic          r_cs, r_wr_e, r_o_e;
   logic [AW-1:0] r_ram_addr;
   logic [DW-1:0] r_ram_wdata;

   logic          w_win;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_arb;
   logic          w_bad;

   assign w_win   = (req0 & req1) ? ~r_last : req1;
   assign w_we    = w_win ? we1 : we0;
   assign w_addr  = w_win ? addr1 : addr0;
   assign w_wdata = w_win ? wdata1 : wdata0;

   // The cycle carrying an error grant is IDLE but the requester still holds req.
   assign w_arb = (r_state == S_IDLE) & (req0 | req1)
                & ~r_gnt0 & ~r_gnt1;

`ifdef RAM_ARB_ADDR_CHECK_EN
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   assign w_bad = ({1'b0, w_addr} >= LP_DEPTH);
`else
   assign w_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_port      <= 1'b0;
         r_addr      <= '0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_rv0       <= 1'b0;
         r_rv1       <= 1'b0;
         r_rd0       <= '0;
         r_rd1       <= '0;
         r_err0      <= 1'b0;
         r_err1      <= 1'b0;
         r_cs        <= 1'b0;
         r_wr_e      <= 1'b0;
         r_o_e       <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else begin
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_rv0       <= 1'b0;
         r_rv1       <= 1'b0;
         r_err0      <= 1'b0;
         r_err1      <= 1'b0;
         r_cs        <= 1'b0;
         r_wr_e      <= 1'b0;
         r_o_e       <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_arb) begin
                  r_last <= w_win;
                  r_port <= w_win;
                  r_addr <= w_addr;
                  r_gnt0 <= ~w_win;
                  r_gnt1 <= w_win;
                  if (w_bad) begin
                     r_err0 <= ~w_win;
                     r_err1 <= w_win;
                  end else begin
                     r_cs        <= 1'b1;
                     r_wr_e      <= w_we;
                     r_ram_addr  <= w_addr;
                     r_ram_wdata <= w_we ? w_wdata : '0;
                     r_state     <= w_we ? S_WRITE : S_READ;
                  end
               end
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            S_READ: begin
               r_cs       <= 1'b1;
               r_o_e      <= 1'b1;
               r_ram_addr <= r_addr;
               r_state    <= S_RDATA;
            end
            default: begin
               r_state <= S_IDLE;
               if (r_port) begin
                  r_rd1 <= ram_rdata;
                  r_rv1 <= 1'b1;
               end else begin
                  r_rd0 <= ram_rdata;
                  r_rv0 <= 1'b1;
               end
            end
         endcase
      end
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign rvalid0   = r_rv0;
   assign rvalid1   = r_rv1;
   assign rdata0    = r_rd0;
   assign rdata1    = r_rd1;
   assign err0      = r_err0;
   assign err1      = r_err1;
   assign ram_cs    = r_cs;
   assign ram_wr_e  = r_wr_e;
   assign ram_o_e   = r_o_e;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised bench for ram_arbiter: transaction-level model with a RAM
// behavioural model; predicts per-cycle strobes, grant order and read data.
module tb_ram_arbiter;

   localparam int NCYC = 3000;

   localparam logic [9:0] B_GNT0 = 10'b10_0000_0000;
   localparam logic [9:0] B_GNT1 = 10'b01_0000_0000;
   localparam logic [9:0] B_RV0  = 10'b00_1000_0000;
   localparam logic [9:0] B_RV1  = 10'b00_0100_0000;
   localparam logic [9:0] B_ERR0 = 10'b00_0010_0000;
   localparam logic [9:0] B_ERR1 = 10'b00_0001_0000;
   localparam logic [9:0] B_CS   = 10'b00_0000_1000;
   localparam logic [9:0] B_WR   = 10'b00_0000_0100;
   localparam logic [9:0] B_OE   = 10'b00_0000_0010;
   localparam logic [9:0] B_BUSY = 10'b00_0000_0001;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [7:0] rdata0, rdata1;
   logic       ram_cs, ram_wr_e, ram_o_e, busy;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .ram_cs(ram_cs), .ram_wr_e(ram_wr_e), .ram_o_e(ram_o_e),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: sync write, registered read, output-enabled bus.
   logic       tb_init;
   logic [7:0] ram_mem [128];
   logic [7:0] ram_tmp;

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 128; i++) ram_mem[i] <= 8'h00;
         ram_tmp <= 8'h00;
      end else begin
         if (ram_cs && ram_wr_e) ram_mem[ram_addr[6:0]] <= ram_wdata;
         if (ram_cs && !ram_wr_e) ram_tmp <= ram_mem[ram_addr[6:0]];
      end
   end

   assign ram_rdata = (ram_cs && ram_o_e && !ram_wr_e) ? ram_tmp : 8'h00;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Reference model state
   logic [7:0] mmem [128];
   logic [9:0] e_ctl  [NCYC+8];
   logic [7:0] e_addr [NCYC+8];
   logic [7:0] e_wd   [NCYC+8];
   logic [7:0] e_rdat [NCYC+8];
   logic [7:0] exp_rd0, exp_rd1;
   bit         mlast;
   int         nxt;

   // Requester state
   bit         p_req [2];
   bit         p_we  [2];
   logic [7:0] p_addr[2];
   logic [7:0] p_wd  [2];

   function automatic logic [9:0] gbit(input int p);
      return (p == 1) ? B_GNT1 : B_GNT0;
   endfunction

   task automatic new_cmd(input int p);
      p_req[p]  = 1'b1;
      p_we[p]   = 1'($urandom_range(0, 1));
      p_addr[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 127))
                                              : 8'($urandom_range(0, 15));
`ifdef RAM_ARB_ADDR_CHECK_EN
      if ($urandom_range(0, 9) == 0) p_addr[p] = 8'($urandom_range(128, 255));
`endif
      p_wd[p] = 8'($urandom);
   endtask

   task automatic model_step(input int c);
      int w;
      logic [7:0] a;
      if (rst) begin
         for (int k = 1; k <= 3; k++) begin
            e_ctl[c+k] = '0; e_addr[c+k] = '0; e_wd[c+k] = '0;
         end
         exp_rd0 = 8'h00;
         exp_rd1 = 8'h00;
         mlast   = 1'b1;
         nxt     = c + 1;
      end else if (c >= nxt && (p_req[0] || p_req[1])) begin
         w     = (p_req[0] && p_req[1]) ? int'(!mlast) : int'(p_req[1]);
         mlast = (w == 1);
         a     = p_addr[w];
         if (a >= 8'd128) begin
            e_ctl[c+1] = gbit(w) | ((w == 1) ? B_ERR1 : B_ERR0);
            nxt = c + 2;
         end else if (p_we[w]) begin
            mmem[a[6:0]] = p_wd[w];
            e_ctl[c+1]  = gbit(w) | B_CS | B_WR | B_BUSY;
            e_addr[c+1] = a;
            e_wd[c+1]   = p_wd[w];
            nxt = c + 2;
         end else begin
            e_ctl[c+1]  = gbit(w) | B_CS | B_BUSY;
            e_addr[c+1] = a;
            e_ctl[c+2]  = B_CS | B_OE | B_BUSY;
            e_addr[c+2] = a;
            e_ctl[c+3]  = (w == 1) ? B_RV1 : B_RV0;
            e_rdat[c+3] = mmem[a[6:0]];
            nxt = c + 3;
         end
      end
   endtask

   task automatic drive_port(input int p, input int c);
      if (p_req[p] && c > 0 && (e_ctl[c-1] & gbit(p)) != '0) begin
         if ($urandom_range(0, 2) != 0) new_cmd(p);
         else p_req[p] = 1'b0;
      end else if (p_req[p]) begin
         if ((e_ctl[c] & gbit(p)) == '0 && $urandom_range(0, 15) == 0)
            p_req[p] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
         new_cmd(p);
      end
   endtask

   initial begin
      rst = 1'b1;
      tb_init = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      for (int i = 0; i < 128; i++) mmem[i] = 8'h00;
      for (int i = 0; i < NCYC + 8; i++) begin
         e_ctl[i] = '0; e_addr[i] = '0; e_wd[i] = '0; e_rdat[i] = '0;
      end
      for (int p = 0; p < 2; p++) begin
         p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0;
      end
      exp_rd0 = 8'h00;
      exp_rd1 = 8'h00;
      mlast   = 1'b1;
      nxt     = 0;

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         tb_init = (cyc < 2);
         rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
         drive_port(0, cyc);
         drive_port(1, cyc);
         req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
         req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];

         @(negedge clk);
         if ((e_ctl[cyc] & B_RV0) != '0) exp_rd0 = e_rdat[cyc];
         if ((e_ctl[cyc] & B_RV1) != '0) exp_rd1 = e_rdat[cyc];
         chk("ctl", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1,
                         ram_cs, ram_wr_e, ram_o_e, busy}), 32'(e_ctl[cyc]));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr[cyc]));
         chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[cyc]));
         chk("rdata0", 32'(rdata0), 32'(exp_rd0));
         chk("rdata1", 32'(rdata1), 32'(exp_rd1));
         model_step(cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
